uart_sync_fifo: RTL

UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo_ptr.sv | 38 +++
 rtl/uart_sync_fifo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared defaults and width helpers for the UART FIFO slice.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Occupancy must represent 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer addresses 0..depth-1; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ptr.sv
// Circular pointer: increments on inc, wraps from FIFO_DEPTH-1 to 0.
// Works for any depth, not only powers of two.
module uart_fifo_ptr
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [ptr_w(FIFO_DEPTH)-1:0]  ptr
);

  localparam int               PTR_W = ptr_w(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(FIFO_DEPTH - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins over increment; explicit wrap at the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with count-derived flags, sticky error flags and
// selectable first-word-fall-through or registered read port.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int FWFT       = 1,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_ack,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  output logic [count_w(FIFO_DEPTH)-1:0]  count,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic                            overflow,
  output logic                            underflow,
  input  logic                            clr_err
);

  localparam int CNT_W = count_w(FIFO_DEPTH);
  localparam int PTR_W = ptr_w(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_ack_q, wr_ack_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Acceptance, occupancy, flags and sticky errors. A read is never
  // accepted on an empty FIFO even if a write lands the same cycle;
  // flush cancels both sides and leaves the error flags alone.
  always_comb begin
    rd_acc   = rd_en && !empty_q && !flush;
    wr_acc   = wr_en && (!full_q || rd_acc) && !flush;
    wr_ack_d = wr_acc;

    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_W'(1);
    end

    full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_W'(AF_LEVEL));
    aempty_d = (count_d <= CNT_W'(AE_LEVEL));

    ovf_d = ovf_q;
    if (wr_en && full_q && !rd_acc && !flush) ovf_d = 1'b1;
    else if (clr_err)                         ovf_d = 1'b0;

    unf_d = unf_q;
    if (rd_en && empty_q && !flush) unf_d = 1'b1;
    else if (clr_err)               unf_d = 1'b0;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  // Storage array, deliberately unreset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= wr_data;
  end

  uart_fifo_ptr #(.FIFO_DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  uart_fifo_ptr #(.FIFO_DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; forced to zero while empty.
      always_comb begin
        rd_data  = empty_q ? '0 : mem_q[rd_ptr];
        rd_valid = !empty_q;
      end
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      // Capture the head on an accepted read; otherwise hold the word.
      always_comb begin
        rd_data_d  = rd_acc ? mem_q[rd_ptr] : rd_data_q;
        rd_valid_d = rd_acc;
      end

      // Registered read port.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign wr_ack       = wr_ack_q;

endmodule
